// File: rtl/membus_pkg.sv
// Shared types and widths for the memory-bus port arbiter family.
package membus_pkg;

    localparam int MA_W  = 15;
    localparam int MB_W  = 36;
    localparam int SEL_W = 4;
    localparam int NPORT = 4;
    localparam int CNT_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_RD_WAIT,
        ST_WR_WAIT,
        ST_RELEASE
    } state_t;

endpackage

// File: rtl/membus_port_arb_if.sv
// Bundle of the four processor-side ports, the memory-side port and arbiter status.
// Per-port signals are indexed by port number (element n belongs to port n).
interface membus_port_arb_if;
    import membus_pkg::*;

    logic [NPORT-1:0] membus_rq_cyc;
    logic [NPORT-1:0] membus_rd_rq;
    logic [NPORT-1:0] membus_wr_rq;
    logic [NPORT-1:0] membus_wr_rs;
    logic [MA_W-1:0]  membus_ma     [NPORT];
    logic [SEL_W-1:0] membus_sel    [NPORT];
    logic [MB_W-1:0]  membus_mb_in  [NPORT];
    logic [NPORT-1:0] membus_addr_ack;
    logic [NPORT-1:0] membus_rd_rs;
    logic [MB_W-1:0]  membus_mb_out [NPORT];

    logic             mem_rq_cyc;
    logic             mem_rd_rq;
    logic             mem_wr_rq;
    logic             mem_wr_rs;
    logic [MA_W-1:0]  mem_ma;
    logic [MB_W-1:0]  mem_mb_out;
    logic             mem_addr_ack;
    logic             mem_rd_rs;
    logic [MB_W-1:0]  mem_mb_in;

    logic [1:0]       grant;
    logic             busy;
    logic             timeout_err;

    // Arbiter side
    modport slave (
        input  membus_rq_cyc, membus_rd_rq, membus_wr_rq, membus_wr_rs,
               membus_ma, membus_sel, membus_mb_in,
               mem_addr_ack, mem_rd_rs, mem_mb_in,
        output membus_addr_ack, membus_rd_rs, membus_mb_out,
               mem_rq_cyc, mem_rd_rq, mem_wr_rq, mem_wr_rs, mem_ma, mem_mb_out,
               grant, busy, timeout_err
    );

    // Processor/memory/environment side
    modport master (
        output membus_rq_cyc, membus_rd_rq, membus_wr_rq, membus_wr_rs,
               membus_ma, membus_sel, membus_mb_in,
               mem_addr_ack, mem_rd_rs, mem_mb_in,
        input  membus_addr_ack, membus_rd_rs, membus_mb_out,
               mem_rq_cyc, mem_rd_rq, mem_wr_rq, mem_wr_rs, mem_ma, mem_mb_out,
               grant, busy, timeout_err
    );

endinterface

// File: rtl/membus_rr_pick.sv
// Four-request priority encoder. With rr_en the search starts at ptr and wraps;
// without it the search always starts at request 0.
module membus_rr_pick (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    input  logic       rr_en,
    output logic [1:0] idx,
    output logic       valid
);

    logic [1:0] start;
    logic [1:0] cand;

    // Walk from the farthest candidate back to the start so the nearest one wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        start = rr_en ? ptr : 2'd0;
        cand  = start;
        for (int i = 3; i >= 0; i--) begin
            cand = start + 2'(i);
            if (req[cand]) begin
                idx   = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/membus_port_arb.sv
// Four-port memory-bus arbiter: decodes module select, grants one port at a time
// and sequences its read / write / read-modify-write handshake to the memory.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// IDLE       | no cycle in progress; pick a requester
// ADDR       | address phase driven to memory, waiting for mem_addr_ack
// RD_WAIT    | read data routed to granted port, waiting for mem_rd_rs
// WR_WAIT    | write data routed to memory, waiting for port's wr_rs
// RELEASE    | memory controls low, waiting for granted rq_cyc to fall
module membus_port_arb
    import membus_pkg::*;
#(
    parameter logic [SEL_W-1:0] MEMSEL_P0   = 4'b0000,
    parameter logic [SEL_W-1:0] MEMSEL_P1   = 4'b0000,
    parameter logic [SEL_W-1:0] MEMSEL_P2   = 4'b0000,
    parameter logic [SEL_W-1:0] MEMSEL_P3   = 4'b0000,
    parameter logic [NPORT-1:0] PORT_EN     = 4'b0001,
    parameter bit               ROUND_ROBIN = 1'b1,
    parameter logic [CNT_W-1:0] TIMEOUT     = 10'd1023
) (
    input logic              clk,
    input logic              reset,
    membus_port_arb_if.slave bus
);

    localparam logic [SEL_W-1:0] MEMSEL [NPORT] = '{MEMSEL_P0, MEMSEL_P1, MEMSEL_P2, MEMSEL_P3};
    // Counter value seen during the TIMEOUT-th cycle of a wait state.
    localparam logic [CNT_W-1:0] TO_LAST = TIMEOUT - CNT_W'(1);

    state_t           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [NPORT-1:0] req;
    logic [1:0]       pick_idx;
    logic             pick_vld;

    logic g_cyc, g_rd, g_wr, g_wrs;
    logic in_cycle, to_hit, live;
    logic addr_hit, rd_hit, wr_hit;

    // A port requests only when enabled and its select matches its jumper.
    always_comb begin
        req = '0;
        for (int n = 0; n < NPORT; n++) begin
            req[n] = bus.membus_rq_cyc[n] & PORT_EN[n] & (bus.membus_sel[n] == MEMSEL[n]);
        end
    end

    membus_rr_pick u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .rr_en (ROUND_ROBIN),
        .idx   (pick_idx),
        .valid (pick_vld)
    );

    assign g_cyc    = bus.membus_rq_cyc[grant_q];
    assign g_rd     = bus.membus_rd_rq[grant_q];
    assign g_wr     = bus.membus_wr_rq[grant_q];
    assign g_wrs    = bus.membus_wr_rs[grant_q];

    assign in_cycle = (state_q == ST_ADDR) || (state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT);
    // A timeout wins over any pulse arriving in the same cycle.
    assign to_hit   = in_cycle && (cnt_q == TO_LAST);
    assign live     = in_cycle && g_cyc && !to_hit;
    assign addr_hit = live && (state_q == ST_ADDR)    && bus.mem_addr_ack;
    assign rd_hit   = live && (state_q == ST_RD_WAIT) && bus.mem_rd_rs;
    assign wr_hit   = live && (state_q == ST_WR_WAIT) && g_wrs;

    // Next-state, grant and rotating-pointer computation.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_idx;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (to_hit || !g_cyc) state_d = ST_RELEASE;
                else if (addr_hit)    state_d = g_rd ? ST_RD_WAIT : (g_wr ? ST_WR_WAIT : ST_RELEASE);
            end
            ST_RD_WAIT: begin
                if (to_hit || !g_cyc) state_d = ST_RELEASE;
                else if (rd_hit)      state_d = g_wr ? ST_WR_WAIT : ST_RELEASE;
            end
            ST_WR_WAIT: begin
                if (to_hit || !g_cyc || wr_hit) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!g_cyc) begin
                    state_d = ST_IDLE;
                    // Pointer holds the port searched first next time.
                    ptr_d   = grant_q + 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stall counter restarts on every state entry and only runs in wait states.
    always_comb begin
        cnt_d = ((state_d != state_q) || !in_cycle) ? '0 : cnt_q + CNT_W'(1);
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Per-port return paths, zero for every port except the granted one.
    always_comb begin
        bus.membus_addr_ack = '0;
        bus.membus_rd_rs    = '0;
        for (int n = 0; n < NPORT; n++) begin
            bus.membus_mb_out[n] = '0;
        end
        if (addr_hit) bus.membus_addr_ack[grant_q] = 1'b1;
        if (rd_hit)   bus.membus_rd_rs[grant_q]    = 1'b1;
        if (state_q == ST_RD_WAIT) bus.membus_mb_out[grant_q] = bus.mem_mb_in;
    end

    assign bus.mem_rq_cyc  = in_cycle && g_cyc;
    assign bus.mem_rd_rq   = in_cycle && g_rd;
    assign bus.mem_wr_rq   = in_cycle && g_wr;
    assign bus.mem_wr_rs   = wr_hit;
    assign bus.mem_ma      = in_cycle ? bus.membus_ma[grant_q] : '0;
    assign bus.mem_mb_out  = (state_q == ST_WR_WAIT) ? bus.membus_mb_in[grant_q] : '0;
    assign bus.grant       = grant_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.timeout_err = to_hit;

endmodule

// File: tb/tb_membus_port_arb.sv
// Bench for membus_port_arb: instance A rotates priority with a short timeout and
// a non-default jumper on port 2; instance B uses fixed priority.
module tb_membus_port_arb;
    import membus_pkg::*;

    logic clk;
    logic reset;

    membus_port_arb_if ifa ();
    membus_port_arb_if ifb ();

    membus_port_arb #(
        .MEMSEL_P0(4'b0000), .MEMSEL_P1(4'b0000), .MEMSEL_P2(4'b0101), .MEMSEL_P3(4'b0000),
        .PORT_EN(4'b1111), .ROUND_ROBIN(1'b1), .TIMEOUT(10'd8)
    ) u_a (.clk(clk), .reset(reset), .bus(ifa));

    membus_port_arb #(
        .MEMSEL_P0(4'b0000), .MEMSEL_P1(4'b0000), .MEMSEL_P2(4'b0000), .MEMSEL_P3(4'b0000),
        .PORT_EN(4'b1111), .ROUND_ROBIN(1'b0), .TIMEOUT(10'd1023)
    ) u_b (.clk(clk), .reset(reset), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    int          ack_cnt  [4] = '{0, 0, 0, 0};
    int          rdrs_cnt [4] = '{0, 0, 0, 0};
    int          wrs_cnt      = 0;
    int          to_cnt       = 0;
    logic [23:0] ev           = '0;

    // Pulse monitor on instance A: counts and the order of the last three events.
    always @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (ifa.membus_addr_ack[n]) ack_cnt[n]  <= ack_cnt[n] + 1;
            if (ifa.membus_rd_rs[n])    rdrs_cnt[n] <= rdrs_cnt[n] + 1;
        end
        if (ifa.mem_wr_rs)   wrs_cnt <= wrs_cnt + 1;
        if (ifa.timeout_err) to_cnt  <= to_cnt + 1;
        if (|ifa.membus_addr_ack)  ev <= {ev[15:0], "A"};
        else if (|ifa.membus_rd_rs) ev <= {ev[15:0], "R"};
        else if (ifa.mem_wr_rs)     ev <= {ev[15:0], "W"};
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle_all();
        ifa.membus_rq_cyc = '0; ifa.membus_rd_rq = '0; ifa.membus_wr_rq = '0; ifa.membus_wr_rs = '0;
        ifb.membus_rq_cyc = '0; ifb.membus_rd_rq = '0; ifb.membus_wr_rq = '0; ifb.membus_wr_rs = '0;
        for (int n = 0; n < 4; n++) begin
            ifa.membus_ma[n] = '0; ifa.membus_sel[n] = '0; ifa.membus_mb_in[n] = '0;
            ifb.membus_ma[n] = '0; ifb.membus_sel[n] = '0; ifb.membus_mb_in[n] = '0;
        end
        ifa.mem_addr_ack = 1'b0; ifa.mem_rd_rs = 1'b0; ifa.mem_mb_in = '0;
        ifb.mem_addr_ack = 1'b0; ifb.mem_rd_rs = 1'b0; ifb.mem_mb_in = '0;
    endtask

    // Leaves the bench just after a falling edge with reset released.
    task automatic do_reset();
        idle_all();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Reference model for random traffic on instance A: the port searched first.
    int m_ptr = 0;

    task automatic rand_txn();
        logic [3:0]      cyc;
        logic [3:0]      elig;
        logic [1:0]      op;
        logic [MB_W-1:0] rdata;
        int              g;
        int              d;
        cyc = 4'($urandom_range(0, 15));
        op  = 2'($urandom_range(0, 3));
        d   = $urandom_range(0, 5);
        for (int n = 0; n < 4; n++) begin
            ifa.membus_sel[n]   = (n == 2) ? (($urandom_range(0, 3) != 0) ? 4'b0101 : 4'b0100) : 4'b0000;
            ifa.membus_ma[n]    = 15'($urandom);
            ifa.membus_mb_in[n] = 36'({$urandom, $urandom});
        end
        ifa.membus_rd_rq  = {4{op[0]}};
        ifa.membus_wr_rq  = {4{op[1]}};
        ifa.membus_rq_cyc = cyc;
        elig = cyc & {1'b1, ifa.membus_sel[2] == 4'b0101, 1'b1, 1'b1};
        g = -1;
        for (int k = 0; k < 4; k++) begin
            if (g < 0 && elig[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
        end
        @(negedge clk); #1;
        if (g < 0) begin
            chk("rand_no_grant", ifa.busy, 1'b0);
            ifa.membus_rq_cyc = '0;
            return;
        end
        chk("rand_grant", ifa.grant, g);
        chk("rand_ma", ifa.mem_ma, ifa.membus_ma[g]);
        chk("rand_rd_rq", ifa.mem_rd_rq, op[0]);
        chk("rand_wr_rq", ifa.mem_wr_rq, op[1]);
        repeat (d) begin
            @(negedge clk); #1;
            chk("rand_no_early_ack", ifa.membus_addr_ack, 4'b0000);
        end
        ifa.mem_addr_ack = 1'b1; #1;
        chk("rand_addr_ack", ifa.membus_addr_ack, 4'b0001 << g);
        @(negedge clk);
        ifa.mem_addr_ack = 1'b0;
        if (op[0]) begin
            rdata = 36'({$urandom, $urandom});
            ifa.mem_mb_in = rdata;
            ifa.mem_rd_rs = 1'b1; #1;
            chk("rand_rd_data", ifa.membus_mb_out[g], rdata);
            chk("rand_rd_rs", ifa.membus_rd_rs, 4'b0001 << g);
            @(negedge clk);
            ifa.mem_rd_rs = 1'b0;
            ifa.mem_mb_in = '0;
        end
        if (op[1]) begin
            #1;
            chk("rand_wr_data", ifa.mem_mb_out, ifa.membus_mb_in[g]);
            ifa.membus_wr_rs[g] = 1'b1; #1;
            chk("rand_wr_rs", ifa.mem_wr_rs, 1'b1);
            @(negedge clk);
            ifa.membus_wr_rs = '0;
        end
        #1;
        chk("rand_release_busy", ifa.busy, 1'b1);
        chk("rand_release_cyc", ifa.mem_rq_cyc, 1'b0);
        ifa.membus_rq_cyc = '0;
        @(negedge clk); #1;
        chk("rand_back_idle", ifa.busy, 1'b0);
        m_ptr = (g + 1) % 4;
    endtask

    typedef struct {
        logic [3:0]  cyc;
        logic [15:0] sels;      // {sel3, sel2, sel1, sel0}
        logic        exp_busy;
        logic [1:0]  exp_grant;
    } vec_t;

    vec_t vecs [8];

    int rr_exp [5] = '{0, 1, 2, 3, 0};

    initial begin
        int b_ack, b_rd, b_oth, b_to, addr_cyc;
        logic hit;
        logic [MB_W-1:0] wdata, rdata;

        // Request-decode vectors, each from reset (rotating pointer at port 0).
        vecs[0] = '{4'b0000, 16'h0000, 1'b0, 2'd0};
        vecs[1] = '{4'b0001, 16'h0500, 1'b1, 2'd0};
        vecs[2] = '{4'b0100, 16'h0500, 1'b1, 2'd2};
        vecs[3] = '{4'b0100, 16'h0400, 1'b0, 2'd0};
        vecs[4] = '{4'b1110, 16'h0530, 1'b1, 2'd2};
        vecs[5] = '{4'b1010, 16'h0500, 1'b1, 2'd1};
        vecs[6] = '{4'b1000, 16'h1000, 1'b0, 2'd0};
        vecs[7] = '{4'b1100, 16'h0400, 1'b1, 2'd3};

        idle_all();
        reset = 1'b1;
        #12;
        chk("reset_busy", ifa.busy, 1'b0);
        chk("reset_grant", ifa.grant, 2'd0);
        chk("reset_mem_rq_cyc", ifa.mem_rq_cyc, 1'b0);
        chk("reset_timeout_err", ifa.timeout_err, 1'b0);
        chk("reset_mem_mb_out", ifa.mem_mb_out, 36'd0);
        do_reset();

        for (int v = 0; v < 8; v++) begin
            do_reset();
            for (int n = 0; n < 4; n++) ifa.membus_sel[n] = vecs[v].sels[4*n +: 4];
            ifa.membus_rq_cyc = vecs[v].cyc;
            @(negedge clk); #1;
            chk("vec_busy", ifa.busy, vecs[v].exp_busy);
            chk("vec_grant", ifa.grant, vecs[v].exp_grant);
            chk("vec_mem_rq_cyc", ifa.mem_rq_cyc, vecs[v].exp_busy);
        end

        // Single read from port 0.
        do_reset();
        b_ack = ack_cnt[0]; b_rd = rdrs_cnt[0];
        b_oth = ack_cnt[1] + ack_cnt[2] + ack_cnt[3] + rdrs_cnt[1] + rdrs_cnt[2] + rdrs_cnt[3];
        ifa.membus_rq_cyc[0] = 1'b1; ifa.membus_rd_rq[0] = 1'b1; ifa.membus_ma[0] = 15'o00017;
        @(negedge clk); #1;
        chk("rd_mem_rq_cyc", ifa.mem_rq_cyc, 1'b1);
        chk("rd_mem_rd_rq", ifa.mem_rd_rq, 1'b1);
        chk("rd_mem_ma", ifa.mem_ma, 15'o00017);
        ifa.mem_addr_ack = 1'b1; #1;
        chk("rd_addr_ack", ifa.membus_addr_ack, 4'b0001);
        @(negedge clk);
        ifa.mem_addr_ack = 1'b0;
        ifa.mem_mb_in = 36'o123456701234;
        ifa.mem_rd_rs = 1'b1; #1;
        chk("rd_data_p0", ifa.membus_mb_out[0], 36'o123456701234);
        chk("rd_data_others", ifa.membus_mb_out[1] | ifa.membus_mb_out[2] | ifa.membus_mb_out[3], 36'd0);
        chk("rd_rd_rs", ifa.membus_rd_rs, 4'b0001);
        @(negedge clk);
        ifa.mem_rd_rs = 1'b0; ifa.mem_mb_in = '0; #1;
        chk("rd_release_busy", ifa.busy, 1'b1);
        chk("rd_release_cyc", ifa.mem_rq_cyc, 1'b0);
        ifa.membus_rq_cyc = '0; ifa.membus_rd_rq = '0;
        @(negedge clk); #1;
        chk("rd_idle", ifa.busy, 1'b0);
        chk("rd_ack_count", ack_cnt[0] - b_ack, 1);
        chk("rd_rs_count", rdrs_cnt[0] - b_rd, 1);
        chk("rd_other_pulses",
            ack_cnt[1] + ack_cnt[2] + ack_cnt[3] + rdrs_cnt[1] + rdrs_cnt[2] + rdrs_cnt[3] - b_oth, 0);

        // Read-modify-write from port 2 with its non-default jumper.
        do_reset();
        wdata = 36'o777000777000;
        rdata = 36'o000111222333;
        ifa.membus_sel[2] = 4'b0100;
        ifa.membus_rq_cyc[2] = 1'b1; ifa.membus_rd_rq[2] = 1'b1; ifa.membus_wr_rq[2] = 1'b1;
        ifa.membus_mb_in[2] = wdata; ifa.membus_ma[2] = 15'o00123;
        @(negedge clk); #1;
        chk("rmw_bad_sel", ifa.busy, 1'b0);
        ifa.membus_sel[2] = 4'b0101;
        @(negedge clk); #1;
        chk("rmw_grant", ifa.grant, 2'd2);
        chk("rmw_mb_out_addr", ifa.mem_mb_out, 36'd0);
        ifa.membus_wr_rs[2] = 1'b1; #1;
        chk("rmw_stray_wr_rs", ifa.mem_wr_rs, 1'b0);
        ifa.membus_wr_rs[2] = 1'b0;
        ifa.mem_addr_ack = 1'b1; #1;
        chk("rmw_addr_ack", ifa.membus_addr_ack, 4'b0100);
        @(negedge clk);
        ifa.mem_addr_ack = 1'b0;
        ifa.mem_mb_in = rdata;
        ifa.mem_rd_rs = 1'b1; #1;
        chk("rmw_mb_out_rd", ifa.mem_mb_out, 36'd0);
        chk("rmw_rd_data", ifa.membus_mb_out[2], rdata);
        chk("rmw_rd_rs", ifa.membus_rd_rs, 4'b0100);
        @(negedge clk);
        ifa.mem_rd_rs = 1'b0; ifa.mem_mb_in = '0; #1;
        chk("rmw_mb_out_wr", ifa.mem_mb_out, wdata);
        ifa.mem_rd_rs = 1'b1; #1;
        chk("rmw_stray_rd_rs", ifa.membus_rd_rs, 4'b0000);
        ifa.mem_rd_rs = 1'b0;
        ifa.membus_wr_rs[2] = 1'b1; #1;
        chk("rmw_wr_rs", ifa.mem_wr_rs, 1'b1);
        @(negedge clk);
        ifa.membus_wr_rs[2] = 1'b0; #1;
        chk("rmw_mb_out_rel", ifa.mem_mb_out, 36'd0);
        chk("rmw_order", ev, {"A", "R", "W"});
        ifa.membus_rq_cyc = '0;
        @(negedge clk); #1;
        chk("rmw_idle", ifa.busy, 1'b0);

        // All four ports requesting: rotating on A, fixed on B, run in lockstep.
        do_reset();
        ifa.membus_sel[2] = 4'b0101;
        ifa.membus_rq_cyc = 4'b1111;
        ifb.membus_rq_cyc = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("rr_grant", ifa.grant, rr_exp[i]);
            chk("fixed_grant", ifb.grant, 2'd0);
            chk("fixed_busy", ifb.busy, 1'b1);
            ifa.mem_addr_ack = 1'b1; ifb.mem_addr_ack = 1'b1; #1;
            chk("rr_addr_ack", ifa.membus_addr_ack, 4'b0001 << rr_exp[i]);
            @(negedge clk);
            ifa.mem_addr_ack = 1'b0; ifb.mem_addr_ack = 1'b0;
            ifa.membus_rq_cyc[rr_exp[i]] = 1'b0;
            ifb.membus_rq_cyc[0] = 1'b0;
            @(negedge clk);
            ifa.membus_rq_cyc[rr_exp[i]] = 1'b1;
            ifb.membus_rq_cyc[0] = 1'b1;
        end
        ifa.membus_rq_cyc = '0;
        ifb.membus_rq_cyc = '0;

        // Memory never acknowledges the address on A (timeout 8).
        do_reset();
        b_ack = ack_cnt[1]; b_to = to_cnt;
        addr_cyc = 0; hit = 1'b0;
        ifa.membus_rq_cyc[1] = 1'b1;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk); #1;
            if (ifa.busy && ifa.mem_rq_cyc) addr_cyc++;
            if (ifa.timeout_err) hit = 1'b1;
        end
        chk("to_seen", hit, 1'b1);
        chk("to_addr_cycles", addr_cyc, 8);
        ifa.mem_addr_ack = 1'b1; #1;
        chk("to_late_ack_blocked", ifa.membus_addr_ack, 4'b0000);
        @(negedge clk);
        ifa.mem_addr_ack = 1'b0; #1;
        chk("to_release_busy", ifa.busy, 1'b1);
        chk("to_release_cyc", ifa.mem_rq_cyc, 1'b0);
        chk("to_pulse_width", ifa.timeout_err, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        chk("to_hold_release", ifa.busy, 1'b1);
        ifa.membus_rq_cyc = '0;
        @(negedge clk); #1;
        chk("to_idle", ifa.busy, 1'b0);
        chk("to_no_ack", ack_cnt[1] - b_ack, 0);
        chk("to_count", to_cnt - b_to, 1);

        // Reset asserted while port 1 waits for read data.
        do_reset();
        ifa.membus_rq_cyc[1] = 1'b1; ifa.membus_rd_rq[1] = 1'b1; ifa.membus_ma[1] = 15'o00777;
        @(negedge clk);
        ifa.mem_addr_ack = 1'b1;
        @(negedge clk);
        ifa.mem_addr_ack = 1'b0;
        ifa.mem_mb_in = 36'h5A5A5A5A5; #1;
        chk("rst_pre_data", ifa.membus_mb_out[1], 36'h5A5A5A5A5);
        #1 reset = 1'b1; #1;
        chk("rst_mem_rq_cyc", ifa.mem_rq_cyc, 1'b0);
        chk("rst_mem_rd_rq", ifa.mem_rd_rq, 1'b0);
        chk("rst_mem_ma", ifa.mem_ma, 15'd0);
        chk("rst_mb_out", ifa.membus_mb_out[1], 36'd0);
        chk("rst_busy", ifa.busy, 1'b0);
        chk("rst_grant", ifa.grant, 2'd0);
        @(negedge clk);
        reset = 1'b0; #1;
        chk("rst_released_idle", ifa.busy, 1'b0);
        @(negedge clk); #1;
        chk("rst_regrant_busy", ifa.busy, 1'b1);
        chk("rst_regrant_cyc", ifa.mem_rq_cyc, 1'b1);
        chk("rst_regrant_port", ifa.grant, 2'd1);
        ifa.mem_mb_in = '0;
        ifa.membus_rq_cyc = '0; ifa.membus_rd_rq = '0;
        @(negedge clk);

        // Random traffic against the rotating-priority model.
        do_reset();
        m_ptr = 0;
        for (int t = 0; t < 40; t++) rand_txn();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/membus_port_arb.md
# membus_port_arb

Four-port memory-bus arbiter that shares one memory unit (core or fast memory) between up to four processor ports. It decodes each port's module select against per-port jumpers, grants one requester at a time by rotating or fixed priority, and routes that requester's address, control and data to a single memory-side port. It sequences the read, write and read-modify-write handshakes to completion, and aborts cycles that stall past a timeout.

## Interface
- MEMSEL_P0..MEMSEL_P3, 4'b0000: module-select jumper per port; a port's request is valid only when its sel equals its jumper.
- PORT_EN, 4'b0001: port enable jumpers, bit n = port n; a disabled port is never granted.
- ROUND_ROBIN, 1: 1 = rotating priority; 0 = fixed priority with p0 highest.
- TIMEOUT, 1023: clk cycles allowed in any wait state before abort; 10-bit counter.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- membus_rq_cyc_pN, membus_rd_rq_pN, membus_wr_rq_pN, membus_wr_rs_pN  in  1 each  per-port request level, read/write levels, write-restart pulse (N = 0..3)
- membus_ma_pN  in  15 [21:35]  word address
- membus_sel_pN  in  4 [18:21]  module select
- membus_mb_in_pN  in  36 [0:35]  write data from processor
- membus_addr_ack_pN, membus_rd_rs_pN  out  1 each  pulses returned to port N only
- membus_mb_out_pN  out  36  read data; zero unless port N is granted in RD_WAIT
- mem_rq_cyc, mem_rd_rq, mem_wr_rq, mem_wr_rs  out  1 each  memory-side controls
- mem_ma  out  15; mem_mb_out  out  36  write data to memory
- mem_addr_ack, mem_rd_rs  in  1 each  pulses from memory; mem_mb_in  in  36  read data
- grant  out  2  granted port index; busy  out  1; timeout_err  out  1  one-cycle pulse

## Operation
- Port N requests when rq_cyc_pN, PORT_EN[N] and sel_pN == MEMSEL_PN are all true.
- States: IDLE, ADDR, RD_WAIT, WR_WAIT, RELEASE.
- IDLE: if any request is present, register grant and go to ADDR. With ROUND_ROBIN=1, search starts at last grant+1 mod 4.
- ADDR: drive mem_rq_cyc, mem_rd_rq, mem_wr_rq and mem_ma from the granted port. On mem_addr_ack, pulse addr_ack to the granted port in the same cycle, then:
  - rd_rq set: go to RD_WAIT.
  - wr_rq only: go to WR_WAIT.
  - neither set: go to RELEASE.
- RD_WAIT: mem_mb_in is routed combinationally to the granted membus_mb_out. On mem_rd_rs, forward the rd_rs pulse. Then go to WR_WAIT if wr_rq is set (read-modify-write), else RELEASE.
- WR_WAIT: mem_mb_out = granted mb_in, otherwise 0. On the granted wr_rs pulse, forward mem_wr_rs and go to RELEASE.
- RELEASE: mem controls low. Wait for the granted rq_cyc to fall, then go to IDLE; the rotating pointer updates on this exit.
- Timeout: the counter clears on every state entry and increments in ADDR, RD_WAIT and WR_WAIT. At TIMEOUT, pulse timeout_err and go to RELEASE without forwarding any pulse.
- The granted port's control levels are re-sampled every cycle; ma and data are not latched.

## Timing
- Reset: state IDLE, grant 0, pointer 0, counter 0. Every output is 0, including busy and timeout_err.
- Grant latency: a request seen in IDLE at edge k appears on mem_rq_cyc after edge k+1.
- Acknowledge paths (addr_ack, rd_rs, wr_rs, data) are combinational from the input pulse and gated by state and grant: zero added latency.
- busy = (state != IDLE).
- Simultaneous requests: exactly one is granted. Requests from other ports wait; they are never dropped or acknowledged.
- rd_rs or wr_rs arriving in the wrong state is ignored.
- If the granted rq_cyc drops in ADDR, RD_WAIT or WR_WAIT, go to RELEASE; that drop satisfies RELEASE, so the next cycle is IDLE.
- Asynchronous reset mid-cycle returns to IDLE immediately, and the memory controls drop in the same cycle.

## Structure
- Shared package membus_pkg: state enum, MA_W=15, MB_W=36, SEL_W=4.
- One sub-module, membus_rr_pick: a 4-request rotating-priority encoder taking req[3:0], ptr[1:0] and rr_en, and returning an index and a valid flag. It is reused by other bus arbiters.

## Test plan
- Single read, p0, ma=15'o00017, mem_mb_in=36'o123456701234:
  - addr_ack_p0 pulses once and rd_rs_p0 pulses once.
  - membus_mb_out_p0 equals the data during the rd_rs cycle.
  - membus_mb_out_p1..p3 stay 0.
- RMW, p2 with MEMSEL_P2=4'b0101, sel=4'b0101, rd_rq=wr_rq=1, mb_in=36'o777000777000:
  - Sequence is addr_ack, rd_rs, then wr_rs.
  - mem_mb_out equals the write data only in WR_WAIT.
  - sel=4'b0100 produces no grant.
- ROUND_ROBIN=1, all four ports requesting continuously: grant order is 0,1,2,3,0. With ROUND_ROBIN=0 the order is 0,0,0.
- TIMEOUT=8, memory never returns mem_addr_ack:
  - timeout_err pulses on the 8th ADDR cycle.
  - No addr_ack reaches the port.
  - Returns to IDLE after the port drops rq_cyc.
- Reset asserted in RD_WAIT: all outputs 0 the same cycle. The first request after release is granted with latency 1.
